// File: rtl/gcd_result_fifo.sv
// Result capture FIFO behind the GCD engine: absorbs one-cycle result pulses and
// re-presents them on a valid/ready stream, counting results lost while full.
module gcd_result_fifo #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  input  logic                       ovf_clear,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop;
  logic             push;
  logic             drop;

  always_comb begin
    out_valid = (count != '0);
    full      = (count == FULL_CNT);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    pop       = out_valid & out_ready;
    push      = in_valid & (~full | pop);
    drop      = in_valid & full & ~pop;
  end

  // Storage has no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear wins, leaving a fresh count of one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (ovf_clear) begin
        drop_count <= DROP_W'(1);
      end else if (drop_count != DROP_MAX) begin
        drop_count <= drop_count + 1'b1;
      end
    end else if (ovf_clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule
